counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter_defs.sv | 18 +
 rtl/counter_arbiter_rr_pick2.sv | 21 ++
 rtl/counter_arbiter.sv | 143 ++++++++++++++
 tb/tb_counter_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_defs.sv
// rtl/counter_arbiter_defs.sv - shared state encodings, widths and burst-length decode for counter_arbiter
package counter_arbiter_defs;

   localparam int LEN_W   = 4;
   localparam int BURST_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A zero length field encodes a full 16-cycle burst.
   function automatic logic [BURST_W-1:0] len_to_burst(input logic [LEN_W-1:0] len);
      return (len == '0) ? BURST_W'(16) : {1'b0, len};
   endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick2.sv
// rtl/counter_arbiter_rr_pick2.sv - two-way round-robin pick, purely combinational
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_idx
);

   // A lone requester always wins; a tie goes to the index not granted last.
   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = 1'b0;
      if (req0 && req1) begin
         grant_idx = ~last_grant;
      end else if (req1) begin
         grant_idx = 1'b1;
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - burst arbiter driving a dual counter's Slt/En; COUNTER_ARBITER_STATS_EN adds grant counters
module counter_arbiter
   import counter_arbiter_defs::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Req0,
   input  logic [LEN_W-1:0] Len0,
   input  logic             Req1,
   input  logic [LEN_W-1:0] Len1,
   output logic             Slt,
   output logic             En,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Busy
`ifdef COUNTER_ARBITER_STATS_EN
   ,
   output logic [15:0]      Grants0,
   output logic [15:0]      Grants1
`endif
);

   state_t             state_q, state_d;
   logic               slt_q, slt_d;
   logic               en_q, en_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               busy_q, busy_d;
   logic               last_q, last_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;

   logic               grant_valid;
   logic               grant_idx;

   rr_pick2 u_pick (
      .req0        (Req0),
      .req1        (Req1),
      .last_grant  (last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Next-state and next-output decode; requests are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      slt_d   = slt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               state_d = ST_RUN;
               slt_d   = grant_idx;
               last_d  = grant_idx;
               cnt_d   = len_to_burst(grant_idx ? Len1 : Len0);
               en_d    = 1'b1;
            end
         end
         ST_RUN: begin
            // cnt_q counts the En cycles still owed including the current one.
            if (cnt_q <= BURST_W'(1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               ack0_d  = ~slt_q;
               ack1_d  = slt_q;
            end else begin
               cnt_d = cnt_q - BURST_W'(1);
               en_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Arbiter state and registered outputs; reset abandons any burst without an Ack.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         slt_q   <= 1'b0;
         en_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         slt_q   <= slt_d;
         en_q    <= en_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Slt  = slt_q;
   assign En   = en_q;
   assign Ack0 = ack0_q;
   assign Ack1 = ack1_q;
   assign Busy = busy_q;

`ifdef COUNTER_ARBITER_STATS_EN
   logic [15:0] grants0_q, grants0_d;
   logic [15:0] grants1_q, grants1_d;
   logic        grant_start;

   assign grant_start = (state_q == ST_IDLE) && grant_valid;

   // Per-requester grant tallies, bumped on entry to RUN and free-running modulo 2^16.
   always_comb begin
      grants0_d = grants0_q;
      grants1_d = grants1_q;
      if (grant_start && !grant_idx) grants0_d = grants0_q + 16'd1;
      if (grant_start &&  grant_idx) grants1_d = grants1_q + 16'd1;
   end

   // Grant tally registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grants0_q <= '0;
         grants1_q <= '0;
      end else begin
         grants0_q <= grants0_d;
         grants1_q <= grants1_d;
      end
   end

   assign Grants0 = grants0_q;
   assign Grants1 = grants1_q;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter with a dual-counter model
module tb_counter_arbiter;

   logic       Clk;
   logic       Reset;
   logic       Req0;
   logic [3:0] Len0;
   logic       Req1;
   logic [3:0] Len1;
   logic       Slt;
   logic       En;
   logic       Ack0;
   logic       Ack1;
   logic       Busy;
`ifdef COUNTER_ARBITER_STATS_EN
   logic [15:0] Grants0;
   logic [15:0] Grants1;
`endif

   int n_vec;
   int n_fail;

   // dual counter attached to Slt/En
   int out0;
   int out1;

   bit en_log   [0:63];
   bit slt_log  [0:63];
   bit ack0_log [0:63];
   bit ack1_log [0:63];
   bit busy_log [0:63];

   counter_arbiter dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Req0  (Req0),
      .Len0  (Len0),
      .Req1  (Req1),
      .Len1  (Len1),
      .Slt   (Slt),
      .En    (En),
      .Ack0  (Ack0),
      .Ack1  (Ack1),
      .Busy  (Busy)
`ifdef COUNTER_ARBITER_STATS_EN
      ,
      .Grants0 (Grants0),
      .Grants1 (Grants1)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (En === 1'b1) begin
         if (Slt) out1 = out1 + 1;
         else     out0 = out0 + 1;
      end
   end

   task automatic collect(input int ncyc, input bit hold);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge Clk); #1;
         en_log[i]   = En;
         slt_log[i]  = Slt;
         ack0_log[i] = Ack0;
         ack1_log[i] = Ack1;
         busy_log[i] = Busy;
         if (!hold) begin
            if (Ack0) Req0 = 1'b0;
            if (Ack1) Req1 = 1'b0;
         end
      end
   endtask

   function automatic int count_en(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (en_log[i]) c++;
      return c;
   endfunction

   function automatic int first_ack(input int n, input bit which);
      for (int i = 0; i < n; i++) begin
         if (!which && ack0_log[i]) return i;
         if (which && ack1_log[i]) return i;
      end
      return -1;
   endfunction

   function automatic int count_ack(input int n, input bit which);
      int c = 0;
      for (int i = 0; i < n; i++) if (which ? ack1_log[i] : ack0_log[i]) c++;
      return c;
   endfunction

   task automatic pulse_reset();
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      n_vec++; if (Slt !== 1'b0) begin n_fail++; $display("FAIL reset_slt: got %b want 0", Slt); end
      n_vec++; if (En !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", En); end
      n_vec++; if ({Ack0, Ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", {Ack0, Ack1}); end
      n_vec++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
`ifdef COUNTER_ARBITER_STATS_EN
      n_vec++; if ({Grants0, Grants1} !== 32'd0) begin n_fail++; $display("FAIL reset_grants: got %h want 0", {Grants0, Grants1}); end
`endif
      Reset = 1'b0;
      @(posedge Clk); #1;
      n_vec++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", Busy); end
   endtask

   task automatic test_single_len3();
      int o0 = out0;
      int o1 = out1;
      Len0 = 4'd3; Req0 = 1'b1;
      collect(6, 1'b0);
      n_vec++; if (count_en(6) !== 3) begin n_fail++; $display("FAIL len3_en_cycles: got %0d want 3", count_en(6)); end
      n_vec++; if ({slt_log[0], slt_log[1], slt_log[2]} !== 3'b000) begin n_fail++; $display("FAIL len3_slt: got %b want 000", {slt_log[0], slt_log[1], slt_log[2]}); end
      n_vec++; if (first_ack(6, 1'b0) !== 3) begin n_fail++; $display("FAIL len3_ack0_pos: got %0d want 3", first_ack(6, 1'b0)); end
      n_vec++; if (count_ack(6, 1'b1) !== 0) begin n_fail++; $display("FAIL len3_no_ack1: got %0d want 0", count_ack(6, 1'b1)); end
      n_vec++; if ({busy_log[0], busy_log[3], busy_log[4]} !== 3'b110) begin n_fail++; $display("FAIL len3_busy: got %b want 110", {busy_log[0], busy_log[3], busy_log[4]}); end
      n_vec++; if (out0 - o0 !== 3) begin n_fail++; $display("FAIL len3_out0: got %0d want 3", out0 - o0); end
      n_vec++; if (out1 - o1 !== 0) begin n_fail++; $display("FAIL len3_out1: got %0d want 0", out1 - o1); end
   endtask

   task automatic test_simultaneous();
      int o0;
      int o1;
      pulse_reset();
      o0 = out0; o1 = out1;
      Len0 = 4'd2; Len1 = 4'd2; Req0 = 1'b1; Req1 = 1'b1;
      collect(8, 1'b0);
      n_vec++; if ({en_log[0], slt_log[0]} !== 2'b10) begin n_fail++; $display("FAIL tie_first_grant: got en/slt %b want 10", {en_log[0], slt_log[0]}); end
      n_vec++; if (first_ack(8, 1'b0) !== 2) begin n_fail++; $display("FAIL tie_ack0_pos: got %0d want 2", first_ack(8, 1'b0)); end
      n_vec++; if ({en_log[2], en_log[3]} !== 2'b00) begin n_fail++; $display("FAIL tie_gap: got %b want 00", {en_log[2], en_log[3]}); end
      n_vec++; if ({en_log[4], slt_log[4], slt_log[5]} !== 3'b111) begin n_fail++; $display("FAIL tie_second_grant: got %b want 111", {en_log[4], slt_log[4], slt_log[5]}); end
      n_vec++; if (first_ack(8, 1'b1) !== 6) begin n_fail++; $display("FAIL tie_ack1_pos: got %0d want 6", first_ack(8, 1'b1)); end
      n_vec++; if (out0 - o0 !== 2) begin n_fail++; $display("FAIL tie_out0: got %0d want 2", out0 - o0); end
      n_vec++; if (out1 - o1 !== 2) begin n_fail++; $display("FAIL tie_out1: got %0d want 2", out1 - o1); end
   endtask

   task automatic test_len16();
      int o1 = out1;
      Len1 = 4'd0; Req1 = 1'b1;
      collect(20, 1'b0);
      n_vec++; if (count_en(20) !== 16) begin n_fail++; $display("FAIL len16_en_cycles: got %0d want 16", count_en(20)); end
      n_vec++; if (first_ack(20, 1'b1) !== 16) begin n_fail++; $display("FAIL len16_ack1_pos: got %0d want 16", first_ack(20, 1'b1)); end
      n_vec++; if ({slt_log[0], slt_log[15]} !== 2'b11) begin n_fail++; $display("FAIL len16_slt: got %b want 11", {slt_log[0], slt_log[15]}); end
      n_vec++; if (out1 - o1 !== 16) begin n_fail++; $display("FAIL len16_out1: got %0d want 16", out1 - o1); end
   endtask

   task automatic test_back_to_back();
      Len0 = 4'd1; Len1 = 4'd1; Req0 = 1'b1; Req1 = 1'b1;
      collect(12, 1'b1);
      Req0 = 1'b0; Req1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_vec++; if ({en_log[3*k], slt_log[3*k]} !== {1'b1, k[0]}) begin n_fail++; $display("FAIL alt_grant%0d: got en/slt %b want %b", k, {en_log[3*k], slt_log[3*k]}, {1'b1, k[0]}); end
         n_vec++; if ({ack0_log[3*k+1], ack1_log[3*k+1]} !== {~k[0], k[0]}) begin n_fail++; $display("FAIL alt_ack%0d: got %b want %b", k, {ack0_log[3*k+1], ack1_log[3*k+1]}, {~k[0], k[0]}); end
         n_vec++; if (en_log[3*k+2] !== 1'b0) begin n_fail++; $display("FAIL alt_idle%0d: got en %b want 0", k, en_log[3*k+2]); end
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset_mid_burst();
      int o0 = out0;
      int o1;
      Len0 = 4'd5; Req0 = 1'b1;
      @(posedge Clk); #1;
      n_vec++; if (En !== 1'b1) begin n_fail++; $display("FAIL abort_started: got en %b want 1", En); end
      @(posedge Clk); #2;
      Reset = 1'b1;
      #1;
      n_vec++; if ({En, Busy} !== 2'b00) begin n_fail++; $display("FAIL abort_en_busy: got %b want 00", {En, Busy}); end
      Req0 = 1'b0;
      @(posedge Clk); #1;
      n_vec++; if ({Ack0, Ack1} !== 2'b00) begin n_fail++; $display("FAIL abort_no_ack: got %b want 00", {Ack0, Ack1}); end
      n_vec++; if (out0 - o0 !== 1) begin n_fail++; $display("FAIL abort_out0: got %0d want 1", out0 - o0); end
      Reset = 1'b0;
      o1 = out1;
      Len1 = 4'd2; Req1 = 1'b1;
      collect(5, 1'b0);
      n_vec++; if ({en_log[0], slt_log[0]} !== 2'b11) begin n_fail++; $display("FAIL resume_grant: got en/slt %b want 11", {en_log[0], slt_log[0]}); end
      n_vec++; if (first_ack(5, 1'b1) !== 2) begin n_fail++; $display("FAIL resume_ack1_pos: got %0d want 2", first_ack(5, 1'b1)); end
      n_vec++; if (count_ack(5, 1'b0) !== 0) begin n_fail++; $display("FAIL resume_no_ack0: got %0d want 0", count_ack(5, 1'b0)); end
      n_vec++; if (out1 - o1 !== 2) begin n_fail++; $display("FAIL resume_out1: got %0d want 2", out1 - o1); end
      n_vec++; if (out0 - o0 !== 1) begin n_fail++; $display("FAIL resume_out0: got %0d want 1", out0 - o0); end
   endtask

`ifdef COUNTER_ARBITER_STATS_EN
   task automatic test_stats();
      bit order [0:4];
      order[0] = 1'b0; order[1] = 1'b0; order[2] = 1'b1; order[3] = 1'b0; order[4] = 1'b1;
      pulse_reset();
      Len0 = 4'd1; Len1 = 4'd1;
      for (int k = 0; k < 5; k++) begin
         if (order[k]) Req1 = 1'b1;
         else          Req0 = 1'b1;
         collect(3, 1'b0);
      end
      n_vec++; if (Grants0 !== 16'd3) begin n_fail++; $display("FAIL stats_grants0: got %0d want 3", Grants0); end
      n_vec++; if (Grants1 !== 16'd2) begin n_fail++; $display("FAIL stats_grants1: got %0d want 2", Grants1); end
      Reset = 1'b1;
      #1;
      n_vec++; if ({Grants0, Grants1} !== 32'd0) begin n_fail++; $display("FAIL stats_reset: got %h want 0", {Grants0, Grants1}); end
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask
`endif

   initial begin
      n_vec = 0; n_fail = 0;
      out0 = 0; out1 = 0;
      Reset = 1'b1;
      Req0 = 1'b0; Req1 = 1'b0;
      Len0 = 4'd0; Len1 = 4'd0;
      test_reset();
      test_single_len3();
      test_simultaneous();
      test_len16();
      test_back_to_back();
      test_reset_mid_burst();
`ifdef COUNTER_ARBITER_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
